// File: rtl/mig_seq_pkg.sv
// Shared types and constants for the MIG truth-table sequencer.
package mig_seq_pkg;

  localparam int N_IN       = 7;
  localparam int MAX_GATES  = 16;
  localparam int SEL_W      = 5;
  localparam int OP_W       = SEL_W + 1;
  localparam int CFG_W      = 3 * OP_W;
  localparam int NG_W       = 5;
  localparam int N_MINTERMS = 128;

  // Gate word layout: {inv2,sel2,inv1,sel1,inv0,sel0}
  localparam int SEL0_LSB = 0;
  localparam int INV0_BIT = 5;
  localparam int SEL1_LSB = 6;
  localparam int INV1_BIT = 11;
  localparam int SEL2_LSB = 12;
  localparam int INV2_BIT = 17;

  // Operand select space: constant 0, then primary inputs, then gate outputs
  localparam logic [SEL_W-1:0] CONST0 = 5'd0;
  localparam logic [SEL_W-1:0] X_BASE = 5'd1;
  localparam logic [SEL_W-1:0] G_BASE = 5'd8;

  typedef enum logic [1:0] {IDLE, EVAL, STORE, DONE} state_t;

  // Resolve a select code to a bit. Gate references at or beyond 'limit'
  // (not yet evaluated, or outside the program) read as 0, as do codes
  // past the last gate.
  function automatic logic sel_value(input logic [SEL_W-1:0]     sel,
                                     input logic [N_IN-1:0]      x,
                                     input logic [MAX_GATES-1:0] node,
                                     input logic [NG_W-1:0]      limit);
    logic [SEL_W-1:0] idx;
    logic             v;
    idx = '0;
    v   = 1'b0;
    if (sel == CONST0) begin
      v = 1'b0;
    end else if (sel < G_BASE) begin
      idx = sel - X_BASE;
      v   = x[idx[2:0]];
    end else begin
      idx = sel - G_BASE;
      if (idx < limit) v = node[idx[3:0]];
    end
    return v;
  endfunction

endpackage

// File: rtl/mig_maj3_unit.sv
// Shared datapath: three-input majority with per-operand inversion.
module mig_maj3_unit (
  input  logic a,
  input  logic b,
  input  logic c,
  input  logic inv_a,
  input  logic inv_b,
  input  logic inv_c,
  output logic y
);

  logic pa, pb, pc;

  // Apply the complement edges, then vote
  always_comb begin
    pa = a ^ inv_a;
    pb = b ^ inv_b;
    pc = c ^ inv_c;
    y  = (pa & pb) | (pa & pc) | (pb & pc);
  end

endmodule

// File: rtl/mig_tt_sequencer.sv
// Time-multiplexed MIG evaluator: runs the gate program once per minterm
// through one MAJ3 unit and collects the selected node into a 128-bit table.
// Handshake: start is a one-cycle request honoured only in IDLE; busy is high
// from the next cycle until done, which pulses for one cycle as busy falls.
module mig_tt_sequencer
  import mig_seq_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cfg_we,
  input  logic [3:0]             cfg_addr,
  input  logic [CFG_W-1:0]       cfg_data,
  input  logic [NG_W-1:0]        num_gates,
  input  logic [SEL_W-1:0]       out_sel,
  input  logic                   start,
  output logic                   busy,
  output logic                   done,
  output logic [N_MINTERMS-1:0]  tt
);

  state_t                state_q, state_d;
  logic [CFG_W-1:0]      prog_q [MAX_GATES];
  logic [NG_W-1:0]       ng_q;
  logic [SEL_W-1:0]      osel_q;
  logic [6:0]            m_q;
  logic [3:0]            g_q;
  logic [MAX_GATES-1:0]  node_q;
  logic                  start_run, eval_en, store_en;
  logic [CFG_W-1:0]      gate_w;
  logic                  op0, op1, op2, maj_y, out_bit;
  logic [NG_W-1:0]       ng_sat;
  logic                  last_gate;

  assign ng_sat    = (num_gates > NG_W'(MAX_GATES)) ? NG_W'(MAX_GATES) : num_gates;
  assign last_gate = ({1'b0, g_q} == (ng_q - NG_W'(1)));

  // Operands for the current gate; only gates before g_q are visible
  assign gate_w  = prog_q[g_q];
  assign op0     = sel_value(gate_w[SEL0_LSB +: SEL_W], m_q, node_q, {1'b0, g_q});
  assign op1     = sel_value(gate_w[SEL1_LSB +: SEL_W], m_q, node_q, {1'b0, g_q});
  assign op2     = sel_value(gate_w[SEL2_LSB +: SEL_W], m_q, node_q, {1'b0, g_q});
  assign out_bit = sel_value(osel_q, m_q, node_q, ng_q);

  mig_maj3_unit u_maj3 (
    .a     (op0),
    .b     (op1),
    .c     (op2),
    .inv_a (gate_w[INV0_BIT]),
    .inv_b (gate_w[INV1_BIT]),
    .inv_c (gate_w[INV2_BIT]),
    .y     (maj_y)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = (ng_sat == '0) ? STORE : EVAL;
      EVAL:    if (last_gate) state_d = STORE;
      STORE: begin
        if (m_q == 7'd127)    state_d = DONE;
        else if (ng_q == '0)  state_d = STORE;
        else                  state_d = EVAL;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs and datapath strobes decoded from state
  always_comb begin
    busy      = 1'b0;
    done      = 1'b0;
    start_run = 1'b0;
    eval_en   = 1'b0;
    store_en  = 1'b0;
    case (state_q)
      IDLE:    start_run = start;
      EVAL:    begin busy = 1'b1; eval_en  = 1'b1; end
      STORE:   begin busy = 1'b1; store_en = 1'b1; end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  // Gate program: writable only while no run is in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MAX_GATES; i++) prog_q[i] <= '0;
    end else if (cfg_we && !busy) begin
      prog_q[cfg_addr] <= cfg_data;
    end
  end

  // Run counters, node registers and the result table
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ng_q   <= '0;
      osel_q <= '0;
      m_q    <= '0;
      g_q    <= '0;
      node_q <= '0;
      tt     <= '0;
    end else begin
      if (start_run) begin
        ng_q   <= ng_sat;
        osel_q <= out_sel;
        m_q    <= '0;
        g_q    <= '0;
        node_q <= '0;
        tt     <= '0;
      end
      if (eval_en) begin
        node_q[g_q] <= maj_y;
        g_q         <= g_q + 4'd1;
      end
      if (store_en) begin
        tt[m_q] <= out_bit;
        node_q  <= '0;
        g_q     <= '0;
        m_q     <= m_q + 7'd1;
      end
    end
  end

endmodule

// File: tb/tb_mig_tt_sequencer.sv
// Bench for mig_tt_sequencer: directed runs checked every cycle against a
// software MIG model, plus literal expectations for the known programs.
module tb_mig_tt_sequencer;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         cfg_we = 1'b0;
  logic [3:0]   cfg_addr = '0;
  logic [17:0]  cfg_data = '0;
  logic [4:0]   num_gates = '0;
  logic [4:0]   out_sel = '0;
  logic         start = 1'b0;
  logic         busy, done;
  logic [127:0] tt;

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  bit chk_on = 1'b0;

  // model state
  logic [17:0]  prog_m [16];
  bit           m_active = 1'b0;
  int           m_pos = 0;
  int           m_len = 0;
  logic [127:0] exp_tt = '0;
  logic [127:0] pend_tt = '0;
  logic [127:0] t4_ref;
  int           c0;

  mig_tt_sequencer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_data  (cfg_data),
    .num_gates (num_gates),
    .out_sel   (out_sel),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .tt        (tt)
  );

  // clock / reset block
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    for (int i = 0; i < 16; i++) prog_m[i] = '0;
  end

  function automatic logic [17:0] gw(input bit i2, input int s2, input bit i1,
                                     input int s1, input bit i0, input int s0);
    return {i2, 5'(s2), i1, 5'(s1), i0, 5'(s0)};
  endfunction

  function automatic int lookup(input int s, input int m, input logic [15:0] gv, input int lim);
    if (s >= 1 && s <= 7) return (m >> (s - 1)) & 1;
    if (s >= 8 && (s - 8) < lim && (s - 8) < 16) return int'(gv[s - 8]);
    return 0;
  endfunction

  // Evaluate the whole program for every minterm, gates in order
  function automatic logic [127:0] model_tt(input int ng, input int osel);
    logic [127:0] r;
    logic [15:0]  gv;
    int           v [3];
    int           s;
    r = '0;
    for (int m = 0; m < 128; m++) begin
      gv = '0;
      for (int g = 0; g < ng; g++) begin
        for (int k = 0; k < 3; k++) begin
          s = int'(prog_m[g][k*6 +: 5]);
          v[k] = lookup(s, m, gv, g) ^ int'(prog_m[g][k*6+5]);
        end
        gv[g] = ((v[0] + v[1] + v[2]) >= 2);
      end
      r[m] = (lookup(osel, m, gv, ng) != 0);
    end
    return r;
  endfunction

  // Reference behaviour: run window, program mirror, expected table
  always @(posedge clk or negedge rst_n) begin
    int ng_eff;
    if (!rst_n) begin
      m_active = 1'b0;
      m_pos    = 0;
      exp_tt   = '0;
      for (int i = 0; i < 16; i++) prog_m[i] = '0;
    end else if (m_active) begin
      if (m_pos == m_len) begin
        m_active = 1'b0;
        m_pos    = 0;
      end else begin
        m_pos++;
        if (m_pos == m_len) exp_tt = pend_tt;
      end
    end else begin
      if (cfg_we) prog_m[cfg_addr] = cfg_data;
      if (start) begin
        ng_eff   = (int'(num_gates) > 16) ? 16 : int'(num_gates);
        m_len    = 128 * (ng_eff + 1) + 1;
        pend_tt  = model_tt(ng_eff, int'(out_sel));
        exp_tt   = '0;
        m_active = 1'b1;
        m_pos    = 1;
      end
    end
  end

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] expv);
    n_chk++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, expv);
  endtask

  task automatic check_int(input string nm, input int act, input int expv);
    n_chk++;
    if (act == expv) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, expv);
  endtask

  // Scoreboard: per-cycle compare against the model
  always @(negedge clk) begin
    bit eb, ed;
    if (chk_on) begin
      eb = m_active && (m_pos < m_len);
      ed = m_active && (m_pos == m_len);
      check("busy", 128'(busy), 128'(eb));
      check("done", 128'(done), 128'(ed));
      if (!eb) check("tt", tt, exp_tt);
    end
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic write_gate(input int addr, input logic [17:0] data);
    cfg_we = 1'b1; cfg_addr = 4'(addr); cfg_data = data;
    step();
    cfg_we = 1'b0;
  endtask

  task automatic start_run(input int ng, input int os, output int c);
    num_gates = 5'(ng); out_sel = 5'(os); start = 1'b1;
    c = cyc;
    step();
    start = 1'b0;
    cfg_we = 1'b0;
  endtask

  task automatic wait_done(input int c, input int lat, input string nm);
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < 4000 && !seen; n++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    check_int({nm, "_latency"}, seen ? (cyc - c) : -1, lat);
  endtask

  // Watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #3 rst_n = 1'b0;
    step(); step();
    check("reset_busy", 128'(busy), '0);
    check("reset_done", 128'(done), '0);
    check("reset_tt", tt, '0);
    rst_n = 1'b1;
    chk_on = 1'b1;
    step();

    // 1: MAJ(x0,x1,x2)
    write_gate(0, gw(0, 3, 0, 2, 0, 1));
    check("t1_model", model_tt(1, 8), {16{8'hE8}});
    start_run(1, 8, c0);
    wait_done(c0, 257, "t1");
    check("t1_tt", tt, {16{8'hE8}});
    step();

    // 2: buffer x0, program write in the same cycle as start
    cfg_we = 1'b1; cfg_addr = 4'd0; cfg_data = gw(1, 0, 0, 0, 0, 1);
    start_run(1, 8, c0);
    wait_done(c0, 257, "t2");
    check("t2_tt", tt, {32{4'hA}});
    step();

    // 3: no gates, output x6
    start_run(0, 7, c0);
    wait_done(c0, 129, "t3");
    check("t3_tt", tt, {64'hFFFF_FFFF_FFFF_FFFF, 64'h0});
    step();

    // 4: six-gate chain
    write_gate(0, gw(0, 3, 0, 2, 0, 1));    // g0 = MAJ(x0,x1,x2)
    write_gate(1, gw(0, 6, 1, 5, 0, 4));    // g1 = MAJ(x3,~x4,x5)
    write_gate(2, gw(0, 7, 0, 9, 0, 8));    // g2 = MAJ(g0,g1,x6)
    write_gate(3, gw(0, 9, 0, 1, 1, 10));   // g3 = MAJ(~g2,x0,g1)
    write_gate(4, gw(1, 0, 1, 8, 0, 11));   // g4 = g3 | ~g0
    write_gate(5, gw(1, 4, 0, 10, 0, 12));  // g5 = MAJ(g4,g2,~x3)
    t4_ref = model_tt(6, 13);
    start_run(6, 13, c0);
    wait_done(c0, 897, "t4");
    check("t4_tt", tt, t4_ref);
    step();

    // 5: start and cfg_we during a run are dropped
    start_run(6, 13, c0);
    repeat (99) step();
    start = 1'b1; num_gates = 5'd3; out_sel = 5'd1;
    cfg_we = 1'b1; cfg_addr = 4'd0; cfg_data = gw(0, 0, 0, 0, 0, 0);
    step();
    start = 1'b0; cfg_we = 1'b0;
    wait_done(c0, 897, "t5");
    check("t5_tt", tt, t4_ref);
    step();
    start_run(6, 13, c0);
    wait_done(c0, 897, "t5_rerun");
    check("t5_prog_kept", tt, t4_ref);
    step();

    // 6: reset mid-run
    start_run(6, 13, c0);
    repeat (299) step();
    rst_n = 1'b0;
    step();
    check("t6_busy", 128'(busy), '0);
    check("t6_tt", tt, '0);
    check("t6_done", 128'(done), '0);
    step();
    rst_n = 1'b1;
    step();
    write_gate(0, gw(0, 3, 0, 2, 0, 1));
    start_run(1, 8, c0);
    wait_done(c0, 257, "t6_fresh");
    check("t6_fresh_tt", tt, {16{8'hE8}});
    step();

    // 7: forward reference reads 0 -> g0 = MAJ(x0,0,1) = x0
    write_gate(0, gw(1, 0, 0, 9, 0, 1));
    write_gate(1, gw(0, 2, 0, 2, 0, 2));
    check("t7_model", model_tt(2, 8), {32{4'hA}});
    start_run(2, 8, c0);
    wait_done(c0, 385, "t7");
    check("t7_tt", tt, {32{4'hA}});
    step();

    // 8: selects past the last gate read 0 -> g0 = MAJ(x1,0,1) = x1
    write_gate(0, gw(1, 31, 0, 30, 0, 2));
    start_run(1, 8, c0);
    wait_done(c0, 257, "t8");
    check("t8_tt", tt, {32{4'hC}});
    step();

    // 9: out_sel names a gate outside the run
    start_run(1, 9, c0);
    wait_done(c0, 257, "t9");
    check("t9_tt", tt, '0);
    step();

    // 10: num_gates saturates at 16; g15 = x2
    write_gate(15, gw(0, 3, 0, 3, 0, 3));
    start_run(20, 23, c0);
    wait_done(c0, 2177, "t10");
    check("t10_tt", tt, {16{8'hF0}});
    step(); step();

    chk_on = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
